pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 16-bit five-stage MISC-V pipeline. Each cycle it drives the PC enable, the load enables of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the squash controls of the two front registers. It detects load-use hazards, squashes wrong-path instructions on a taken branch, and freezes the pipe while data memory is not ready. A halt/resume state holds the pipe frozen, and a timeout on memory waits forces a halt.

---
 rtl/pipe_hazard_ctrl_if.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 71 +++++++
 tb/tb_pipe_hazard_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline-side hazard inputs and stall/flush controls
interface pipe_hazard_ctrl_if #(
   parameter int REG_AW = 4,
   parameter int CNT_W  = 16
);
   logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
   logic              id_uses_rs1, id_uses_rs2;
   logic              ex_mem_read, ex_branch_taken;
   logic              mem_req, mem_ready;
   logic              halt_req, resume;
   logic              pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic              if_id_flush, id_ex_flush;
   logic [1:0]        state;
   logic              timeout_err;
   logic [CNT_W-1:0]  stall_count;

   modport master (
      output id_rs1, id_rs2, ex_rd, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken,
             mem_req, mem_ready, halt_req, resume,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
             state, timeout_err, stall_count
   );

   modport slave (
      input  id_rs1, id_rs2, ex_rd, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken,
             mem_req, mem_ready, halt_req, resume,
      output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
             state, timeout_err, stall_count
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the five-stage pipeline
module pipe_hazard_ctrl #(
   parameter int REG_AW  = 4,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 16
) (
   input logic               clk,
   input logic               reset,
   pipe_hazard_ctrl_if.slave bus
);
   localparam logic [1:0] RUN = 2'b00, MEM_WAIT = 2'b01, HALT = 2'b10;
   localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

   logic [1:0]       cur_state, nxt_state;
   logic [WW-1:0]    wait_cnt;
   logic             err_flag;
   logic [CNT_W-1:0] stall_cnt;
   logic             hazard, mem_stall, active, expired;

   assign hazard = bus.ex_mem_read && bus.ex_rd != REG_AW'(0) &&
                   ((bus.id_uses_rs1 && bus.id_rs1 == bus.ex_rd) ||
                    (bus.id_uses_rs2 && bus.id_rs2 == bus.ex_rd));
   assign mem_stall = bus.mem_req && !bus.mem_ready;
   // active: the pipe may advance this cycle, so branch/load-use rules apply
   assign active  = (cur_state == RUN && !mem_stall) || (cur_state == MEM_WAIT && bus.mem_ready);
   assign expired = cur_state == MEM_WAIT && !bus.mem_ready && wait_cnt == WW'(TIMEOUT - 1);

   // state register
   always_ff @(posedge clk)
      cur_state <= reset ? RUN : nxt_state;

   // next-state logic; a ready memory always beats the timeout
   always_comb begin
      nxt_state = RUN;
      case (cur_state)
         RUN:      nxt_state = mem_stall ? MEM_WAIT : bus.halt_req ? HALT : RUN;
         MEM_WAIT: nxt_state = bus.mem_ready ? (bus.halt_req ? HALT : RUN) : expired ? HALT : MEM_WAIT;
         HALT:     nxt_state = bus.resume ? RUN : HALT;
         default:  nxt_state = RUN;
      endcase
   end

   // Mealy enables/flushes; reset forces everything closed and both front registers to bubbles
   always_comb begin
      bus.pc_en       = !reset && active && (bus.ex_branch_taken || !hazard);
      bus.if_id_en    = !reset && active && (bus.ex_branch_taken || !hazard);
      bus.id_ex_en    = !reset && active;
      bus.ex_mem_en   = !reset && active;
      bus.mem_wb_en   = !reset && active;
      bus.if_id_flush = reset || (active && bus.ex_branch_taken);
      bus.id_ex_flush = reset || (active && (bus.ex_branch_taken || hazard));
   end

   // wait counter restarts from every RUN cycle, sticky timeout flag, saturating stall counter
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt  <= '0;
         err_flag  <= 1'b0;
         stall_cnt <= '0;
      end else begin
         if (cur_state == RUN) wait_cnt <= '0;
         else if (cur_state == MEM_WAIT && !bus.mem_ready && !expired) wait_cnt <= wait_cnt + 1'b1;
         if (expired) err_flag <= 1'b1;
         if (!bus.pc_en && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign bus.state       = cur_state;
   assign bus.timeout_err = err_flag;
   assign bus.stall_count = stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of stall, flush, memory-wait, timeout and halt behaviour
module tb_pipe_hazard_ctrl;
   logic clk = 1'b0;
   logic reset;
   int   vecs = 0;
   int   errs = 0;

   pipe_hazard_ctrl_if #(.REG_AW(4), .CNT_W(4)) bus ();

   pipe_hazard_ctrl #(.REG_AW(4), .TIMEOUT(4), .CNT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush}
   wire [6:0] outs = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                      bus.if_id_flush, bus.id_ex_flush};

   task automatic apply(input logic [3:0] rs1, input logic [3:0] rs2, input logic u1, input logic u2,
                        input logic [3:0] rd, input logic mr, input logic br, input logic req,
                        input logic rdy, input logic hr, input logic res);
      bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_uses_rs1 = u1; bus.id_uses_rs2 = u2;
      bus.ex_rd = rd; bus.ex_mem_read = mr; bus.ex_branch_taken = br;
      bus.mem_req = req; bus.mem_ready = rdy; bus.halt_req = hr; bus.resume = res;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // check the settled Mealy outputs (and registered status when full), then advance one clock
   task automatic cyc(input string tag, input logic [6:0] e_out, input logic [1:0] e_st,
                      input int e_cnt, input logic e_err, input bit full);
      #1;
      chk({tag, ".outs"}, 32'(outs), 32'(e_out));
      if (full) begin
         chk({tag, ".state"}, 32'(bus.state), 32'(e_st));
         chk({tag, ".stall_count"}, 32'(bus.stall_count), 32'(e_cnt));
         chk({tag, ".timeout_err"}, 32'(bus.timeout_err), 32'(e_err));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("reset0", 7'b0000011, 2'b00, 0, 0, 0);
      cyc("reset1", 7'b0000011, 2'b00, 0, 0, 1);
      reset = 1'b0;
      cyc("run_idle", 7'b1111100, 2'b00, 0, 0, 1);
      // load-use on rs2
      apply(0, 3, 0, 1, 3, 1, 0, 0, 0, 0, 0);
      cyc("lu_rs2", 7'b0011101, 2'b00, 0, 0, 1);
      apply(0, 3, 0, 1, 3, 0, 0, 0, 0, 0, 0);
      cyc("lu_after", 7'b1111100, 2'b00, 1, 0, 1);
      // register 0 never hazards
      apply(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
      cyc("lu_r0", 7'b1111100, 2'b00, 1, 0, 1);
      // load-use on rs1, then same registers but source unused
      apply(5, 0, 1, 0, 5, 1, 0, 0, 0, 0, 0);
      cyc("lu_rs1", 7'b0011101, 2'b00, 1, 0, 1);
      apply(5, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0);
      cyc("lu_unused", 7'b1111100, 2'b00, 2, 0, 1);
      // branch beats load-use
      apply(0, 3, 0, 1, 3, 1, 1, 0, 0, 0, 0);
      cyc("branch_lu", 7'b1111111, 2'b00, 2, 0, 1);
      // three-cycle memory wait
      apply(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      cyc("mw_enter", 7'b0000000, 2'b00, 2, 0, 1);
      cyc("mw_wait1", 7'b0000000, 2'b01, 3, 0, 1);
      cyc("mw_wait2", 7'b0000000, 2'b01, 4, 0, 1);
      apply(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      cyc("mw_release", 7'b1111100, 2'b01, 5, 0, 1);
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("mw_back", 7'b1111100, 2'b00, 5, 0, 1);
      // load-use held during a memory wait is acted on at release
      apply(0, 3, 0, 1, 3, 1, 0, 1, 0, 0, 0);
      cyc("mwlu_enter", 7'b0000000, 2'b00, 5, 0, 1);
      apply(0, 3, 0, 1, 3, 1, 0, 1, 1, 0, 0);
      cyc("mwlu_release", 7'b0011101, 2'b01, 6, 0, 1);
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("mwlu_back", 7'b1111100, 2'b00, 7, 0, 1);
      // timeout after exactly four MEM_WAIT cycles
      apply(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      cyc("to_enter", 7'b0000000, 2'b00, 7, 0, 1);
      cyc("to_w0", 7'b0000000, 2'b01, 8, 0, 1);
      cyc("to_w1", 7'b0000000, 2'b01, 9, 0, 1);
      cyc("to_w2", 7'b0000000, 2'b01, 10, 0, 1);
      cyc("to_w3", 7'b0000000, 2'b01, 11, 0, 1);
      cyc("to_halt0", 7'b0000000, 2'b10, 12, 1, 1);
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("to_halt1", 7'b0000000, 2'b10, 13, 1, 1);
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc("to_resume", 7'b0000000, 2'b10, 14, 1, 1);
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("to_run", 7'b1111100, 2'b00, 15, 1, 1);
      // halt request completes its cycle, then freezes; counter saturates at 15
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      cyc("halt_req", 7'b1111100, 2'b00, 15, 1, 1);
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("halt_a", 7'b0000000, 2'b10, 15, 1, 1);
      cyc("halt_b", 7'b0000000, 2'b10, 15, 1, 1);
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc("halt_resume", 7'b0000000, 2'b10, 15, 1, 1);
      cyc("run_resume_ignored", 7'b1111100, 2'b00, 15, 1, 1);
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("run_still", 7'b1111100, 2'b00, 15, 1, 1);
      // reset while halted
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      cyc("halt2_req", 7'b1111100, 2'b00, 15, 1, 1);
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      cyc("halt_reset", 7'b0000011, 2'b10, 15, 1, 0);
      reset = 1'b0;
      cyc("post_reset", 7'b1111100, 2'b00, 0, 0, 1);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
